// File: rtl/lbo_capture_pkg.sv
// ============================================================================
// Module   : lbo_capture_pkg
// Purpose  : Shared encodings and widths for the LBO write-stream recorder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbo_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } cap_state_e;

    localparam logic [1:0] c_SEL_DATA = 2'd0;
    localparam logic [1:0] c_SEL_AT   = 2'd1;
    localparam logic [1:0] c_SEL_STAT = 2'd2;
    localparam logic [1:0] c_SEL_ZERO = 2'd3;

    localparam int c_LBO_ADDR_W = 17;
    localparam int c_TS_W       = 15;
    localparam int c_DATA_W     = 32;
    localparam int c_ENTRY_W    = c_TS_W + c_LBO_ADDR_W + c_DATA_W;

    localparam logic [c_TS_W-1:0] c_TS_MAX = '1;
    localparam logic [c_TS_W-1:0] c_TS_ONE = {{(c_TS_W-1){1'b0}}, 1'b1};

    // Timestamps stick at the ceiling so long captures never alias back to 0.
    function automatic logic [c_TS_W-1:0] ts_inc(input logic [c_TS_W-1:0] ts);
        return (ts == c_TS_MAX) ? ts : ts + c_TS_ONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lbo_capture_dpram.sv
// ============================================================================
// Module   : capture_dpram
// Purpose  : Simple dual-port RAM, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_dpram #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

`default_nettype wire

// File: rtl/lbo_capture.sv
// ============================================================================
// Module   : lbo_capture
// Purpose  : Armed recorder of LBO write strobes with timestamps and readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbo_capture
    import lbo_capture_pkg::*;
#(
    parameter int DEPTH_LOG2   = 5,
    parameter int QUIET_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              lbo_data,
    input  logic                     lbo_write,
    input  logic [16:0]              lbo_addr,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [DEPTH_LOG2+1:0]    rd_addr,
    output logic [31:0]              rd_data,
    output logic [DEPTH_LOG2:0]      count,
    output logic [1:0]               state,
    output logic                     overflow
);

    localparam logic [DEPTH_LOG2:0] c_FULL       = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] c_LAST       = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [7:0]          c_QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam int                  c_PAD_W      = c_DATA_W - 3 - (DEPTH_LOG2 + 1);

    cap_state_e              r_state, w_state_nxt;
    logic [DEPTH_LOG2:0]     r_count, w_count_nxt;
    logic                    r_overflow, w_overflow_nxt;
    logic [c_TS_W-1:0]       r_ts, w_ts_nxt;
    logic [7:0]              r_quiet, w_quiet_nxt;
    logic                    w_store;
    logic [c_TS_W-1:0]       w_store_ts;

    logic [DEPTH_LOG2-1:0]   w_rd_idx;
    logic [c_ENTRY_W-1:0]    w_ram_q;
    logic [1:0]              r_sel;
    logic                    r_hit;
    logic [c_DATA_W-1:0]     r_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ts       <= '0;
            r_quiet    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_ts       <= w_ts_nxt;
            r_quiet    <= w_quiet_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_ts_nxt       = r_ts;
        w_quiet_nxt    = r_quiet;
        w_store        = 1'b0;
        w_store_ts     = r_ts;
        if (clear) begin
            w_state_nxt    = IDLE;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
            w_ts_nxt       = '0;
            w_quiet_nxt    = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (arm) begin
                        w_state_nxt    = ARMED;
                        w_count_nxt    = '0;
                        w_overflow_nxt = 1'b0;
                        w_ts_nxt       = '0;
                        w_quiet_nxt    = '0;
                    end
                end
                ARMED: begin
                    if (lbo_write) begin
                        w_store     = 1'b1;
                        w_store_ts  = '0;
                        w_count_nxt = c_CNT_ONE;
                        w_ts_nxt    = c_TS_ONE;
                        w_quiet_nxt = '0;
                        w_state_nxt = (r_count == c_LAST) ? DONE : CAPT;
                    end
                end
                CAPT: begin
                    w_ts_nxt = ts_inc(r_ts);
                    if (lbo_write) begin
                        w_store     = 1'b1;
                        w_count_nxt = r_count + c_CNT_ONE;
                        w_quiet_nxt = '0;
                        if (r_count == c_LAST) begin
                            w_state_nxt = DONE;
                        end
                    end else if (r_quiet == c_QUIET_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_quiet_nxt = r_quiet + 8'd1;
                    end
                end
                DONE: begin
                    if (arm) begin
                        w_state_nxt    = ARMED;
                        w_count_nxt    = '0;
                        w_overflow_nxt = 1'b0;
                        w_ts_nxt       = '0;
                        w_quiet_nxt    = '0;
                    end else if (lbo_write && (r_count == c_FULL)) begin
                        w_overflow_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign w_rd_idx = rd_addr[DEPTH_LOG2+1:2];

    capture_dpram #(
        .WIDTH  (c_ENTRY_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_count[DEPTH_LOG2-1:0]),
        .i_wdata ({w_store_ts, lbo_addr, lbo_data}),
        .i_raddr (w_rd_idx),
        .o_rdata (w_ram_q)
    );

    // Validity and status are captured alongside the RAM read so all words share one latency;
    // comparing against the pre-write count hides an entry during the cycle it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= c_SEL_ZERO;
            r_hit  <= 1'b0;
            r_stat <= '0;
        end else begin
            r_sel  <= rd_addr[1:0];
            r_hit  <= ({1'b0, w_rd_idx} < r_count);
            r_stat <= {r_state, r_overflow, {c_PAD_W{1'b0}}, r_count};
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (r_sel)
            c_SEL_DATA: rd_data = r_hit ? w_ram_q[c_DATA_W-1:0] : '0;
            c_SEL_AT:   rd_data = r_hit ? w_ram_q[c_ENTRY_W-1:c_DATA_W] : '0;
            c_SEL_STAT: rd_data = r_stat;
            default:    rd_data = '0;
        endcase
    end

    assign count    = r_count;
    assign state    = r_state;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_lbo_capture.sv
// ============================================================================
// Module   : tb_lbo_capture
// Purpose  : Self-checking bench for lbo_capture against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lbo_capture;
    import lbo_capture_pkg::*;

    localparam int DL    = 5;
    localparam int DEPTH = 32;
    localparam int Q     = 255;
    localparam int DL2   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1, clear = 1'b0, arm = 1'b0, arm2 = 1'b0, lbo_write = 1'b0;
    logic [31:0]    lbo_data = '0;
    logic [16:0]    lbo_addr = '0;
    logic [DL+1:0]  rd_addr  = '0;
    logic [DL2+1:0] rd_addr2 = '0;

    logic [31:0] rd_data, rd_data2;
    logic [DL:0] count;
    logic [DL2:0] count2;
    logic [1:0]  state, state2;
    logic        overflow, overflow2;

    lbo_capture #(.DEPTH_LOG2(DL), .QUIET_CYCLES(Q)) dut (
        .clk(clk), .rst(rst), .lbo_data(lbo_data), .lbo_write(lbo_write),
        .lbo_addr(lbo_addr), .arm(arm), .clear(clear), .rd_addr(rd_addr),
        .rd_data(rd_data), .count(count), .state(state), .overflow(overflow)
    );

    // Deep instance so the 15-bit timestamp can be driven into saturation.
    lbo_capture #(.DEPTH_LOG2(DL2), .QUIET_CYCLES(Q)) dut_sat (
        .clk(clk), .rst(rst), .lbo_data(lbo_data), .lbo_write(lbo_write),
        .lbo_addr(lbo_addr), .arm(arm2), .clear(clear), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .count(count2), .state(state2), .overflow(overflow2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: capture described by edge numbers, not by counters.
    longint      cyc = 0, m_first = 0, m_last = 0;
    int          m_state = 0, m_count = 0, m_ovf = 0;
    logic [31:0] m_data [DEPTH];
    logic [16:0] m_addr [DEPTH];
    int          m_ts   [DEPTH];
    logic [31:0] m_rd = '0;

    logic [31:0] fd [35];
    logic [16:0] fa [35];
    logic [31:0] s_data [200];
    logic [16:0] s_addr [200];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic record();
        longint ts;
        ts = cyc - m_first;
        if (ts > 32767) ts = 32767;
        m_data[m_count] = lbo_data;
        m_addr[m_count] = lbo_addr;
        m_ts[m_count]   = int'(ts);
        m_count++;
        m_last = cyc;
    endtask

    task automatic tick();
        int idx, sel;
        logic [31:0] exp_rd;
        @(posedge clk);
        cyc++;
        idx = int'(rd_addr[DL+1:2]);
        sel = int'(rd_addr[1:0]);
        exp_rd = 32'd0;
        if (sel == 0 && idx < m_count)      exp_rd = m_data[idx];
        else if (sel == 1 && idx < m_count) exp_rd = {15'(m_ts[idx]), m_addr[idx]};
        else if (sel == 2)                  exp_rd = {2'(m_state), 1'(m_ovf), 23'd0, 6'(m_count)};
        m_rd = rst ? 32'd0 : exp_rd;
        if (rst || clear) begin
            m_state = 0; m_count = 0; m_ovf = 0;
        end else begin
            case (m_state)
                0: if (arm) begin m_state = 1; m_count = 0; m_ovf = 0; end
                1: if (lbo_write) begin m_first = cyc; record(); m_state = 2; end
                2: begin
                    if (lbo_write) begin
                        record();
                        if (m_count == DEPTH) m_state = 3;
                    end else if (cyc - m_last == Q) begin
                        m_state = 3;
                    end
                end
                default: begin
                    if (arm) begin m_state = 1; m_count = 0; m_ovf = 0; end
                    else if (lbo_write && m_count == DEPTH) m_ovf = 1;
                end
            endcase
        end
        @(negedge clk);
        check("state",    32'(state),    32'(m_state));
        check("count",    32'(count),    32'(m_count));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_data",  rd_data,       m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 7'($urandom);
            tick();
        end
    endtask

    task automatic wr(input logic [16:0] a, input logic [31:0] d);
        lbo_write = 1'b1; lbo_addr = a; lbo_data = d;
        tick();
        lbo_write = 1'b0;
    endtask

    task automatic rd(input int idx, input int sel);
        rd_addr = {5'(idx), 2'(sel)};
        tick();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        int kts;
        // Reset
        repeat (3) tick();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_rd",    rd_data, 32'd0);

        // Writes while IDLE are ignored
        for (int i = 0; i < 3; i++) wr(17'($urandom), $urandom);
        check("idle_count", 32'(count), 32'd0);
        check("idle_state", 32'(state), 32'd0);

        // Baseline: two writes three cycles apart, then silence
        pulse_arm();
        idle(9);
        wr(17'd4096, 32'h5);
        idle(2);
        wr(17'd17, 32'h1234);
        idle(Q - 1);
        check("base_still_capt", 32'(state), 32'd2);
        idle(1);
        check("base_done", 32'(state), 32'd3);
        check("base_count", 32'(count), 32'd2);
        rd(0, 3);
        check("rd_zero_sel", rd_data, 32'd0);
        rd(1, 1);
        check("rd_latency_e1_at", rd_data, {15'd3, 17'd17});
        rd(0, 1);
        check("e0_at", rd_data, {15'd0, 17'd4096});
        rd(0, 0);
        check("e0_data", rd_data, 32'h5);
        rd(1, 0);
        check("e1_data", rd_data, 32'h1234);
        rd(5, 0);
        check("rd_beyond_count", rd_data, 32'd0);
        rd(7, 2);
        check("status_word", rd_data, {2'd3, 1'b0, 23'd0, 6'd2});

        // DONE but not full: writes ignored
        wr(17'($urandom), $urandom);
        wr(17'($urandom), $urandom);
        check("done_nf_count", 32'(count), 32'd2);
        check("done_nf_ovf", 32'(overflow), 32'd0);

        // Re-arm and fill to full with overflow
        pulse_arm();
        check("rearm_count", 32'(count), 32'd0);
        check("rearm_state", 32'(state), 32'd1);
        for (int i = 0; i < 35; i++) begin
            fa[i] = 17'($urandom);
            fd[i] = $urandom;
            wr(fa[i], fd[i]);
            if (i == 30) check("fill_31_capt", 32'(state), 32'd2);
            if (i == 31) begin
                check("full_state", 32'(state), 32'd3);
                check("full_count", 32'(count), 32'd32);
                check("full_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_count_kept", 32'(count), 32'd32);
        rd(31, 1);
        check("e31_at", rd_data, {15'd31, fa[31]});
        rd(31, 0);
        check("e31_data", rd_data, fd[31]);
        rd(0, 1);
        check("f_e0_at", rd_data, {15'd0, fa[0]});

        // Re-arm clears flags; clear beats arm during CAPT
        pulse_arm();
        check("rearm2_ovf", 32'(overflow), 32'd0);
        check("rearm2_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) wr(17'($urandom), $urandom);
        check("pre_clear_capt", 32'(state), 32'd2);
        clear = 1'b1; arm = 1'b1;
        tick();
        clear = 1'b0; arm = 1'b0;
        check("clear_state", 32'(state), 32'd0);
        check("clear_count", 32'(count), 32'd0);

        // Read of the entry being written returns zero
        pulse_arm();
        rd_addr = {5'd0, 2'd0};
        wr(17'h1abcd, 32'hcafe_f00d);
        check("rd_during_wr", rd_data, 32'd0);
        rd(0, 0);
        check("rd_after_wr", rd_data, 32'hcafe_f00d);

        // Reset mid-capture
        wr(17'($urandom), $urandom);
        rd_addr = {5'd0, 2'd2};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_rd", rd_data, 32'd0);

        // Timestamp saturation on the deep instance
        arm = 1'b1; arm2 = 1'b1;
        tick();
        arm = 1'b0; arm2 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            s_addr[k] = 17'($urandom);
            s_data[k] = $urandom;
            wr(s_addr[k], s_data[k]);
            if (k < 199) idle(199);
        end
        check("sat_state", 32'(state2), 32'd2);
        check("sat_count", 32'(count2), 32'd200);
        check("sat_ovf", 32'(overflow2), 32'd0);
        foreach (s_addr[k]) begin
            if (k == 1 || k == 163 || k == 164 || k == 199) begin
                kts = (k * 200 > 32767) ? 32767 : k * 200;
                rd_addr2 = {8'(k), 2'd1};
                tick();
                check("sat_at", rd_data2, {15'(kts), s_addr[k]});
            end
        end
        rd_addr2 = {8'd199, 2'd0};
        tick();
        check("sat_data199", rd_data2, s_data[199]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
